// File: rtl/game_pkg.sv
// Shared maze-game constants: one-hot output encodings, map size defaults,
// controller state encoding and the state-to-game_state decode.
package game_pkg;

    localparam int MAP_WIDTH_DEF  = 30;
    localparam int MAP_HEIGHT_DEF = 21;
    localparam int TIMER_W        = 28;

    localparam logic [3:0] GS_MENU = 4'b0001;
    localparam logic [3:0] GS_GAME = 4'b0010;
    localparam logic [3:0] GS_LOST = 4'b0100;
    localparam logic [3:0] GS_WON  = 4'b1000;

    localparam logic [2:0] SEL_START = 3'b001;
    localparam logic [2:0] SEL_DIFF  = 3'b010;
    localparam logic [2:0] SEL_INSTR = 3'b100;

    localparam logic [1:0] SUB_MAIN  = 2'b00;
    localparam logic [1:0] SUB_DIFF  = 2'b01;
    localparam logic [1:0] SUB_INSTR = 2'b10;

    localparam logic [2:0] DIFF_EASY = 3'b001;
    localparam logic [2:0] DIFF_MED  = 3'b010;
    localparam logic [2:0] DIFF_HARD = 3'b100;

    typedef enum logic [2:0] {
        ST_MENU = 3'd0,
        ST_SHOW = 3'd1,
        ST_PLAY = 3'd2,
        ST_RD   = 3'd3,
        ST_EVAL = 3'd4,
        ST_LOST = 3'd5,
        ST_WON  = 3'd6
    } state_t;

    // Preview, play and the move check all present as "in game" to the renderer.
    function automatic logic [3:0] state_to_gs(input state_t s);
        case (s)
            ST_MENU: return GS_MENU;
            ST_LOST: return GS_LOST;
            ST_WON:  return GS_WON;
            default: return GS_GAME;
        endcase
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Button, map ROM and renderer signals of the game flow controller.
interface game_flow_ctrl_if
    import game_pkg::*;
#(
    parameter int MAP_WIDTH = MAP_WIDTH_DEF
);
    logic                 btn_up;
    logic                 btn_down;
    logic                 btn_left;
    logic                 btn_right;
    logic                 btn_center;
    logic [4:0]           rom_addr;
    logic [MAP_WIDTH-1:0] rom_data;
    logic [7:0]           player_x;
    logic [7:0]           player_y;
    logic [3:0]           game_state;
    logic [2:0]           menu_sel;
    logic [1:0]           menu_sub;
    logic [2:0]           difficulty;
    logic                 map_visible;
    logic [1:0]           lives;
    logic                 busy;

    modport master (
        input  btn_up, btn_down, btn_left, btn_right, btn_center, rom_data,
        output rom_addr, player_x, player_y, game_state, menu_sel, menu_sub,
               difficulty, map_visible, lives, busy
    );

    modport slave (
        output btn_up, btn_down, btn_left, btn_right, btn_center, rom_data,
        input  rom_addr, player_x, player_y, game_state, menu_sel, menu_sub,
               difficulty, map_visible, lives, busy
    );
endinterface

// File: rtl/show_timer.sv
// Loadable down-counter timing the map preview; parks at zero.
module show_timer
    import game_pkg::*;
#(
    parameter int WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    // Load takes priority; decrement never wraps past the terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && !zero) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Maze game sequencer: menus, timed map preview, wall-checked moves.
//
// state | meaning
// MENU  | main menu / difficulty edit / instructions page
// SHOW  | map preview, walls drawn until the timer expires
// PLAY  | waiting for a direction pulse
// RD    | ROM row address issued, data arrives next cycle
// EVAL  | ROM row sampled, move applied or life lost
// LOST  | out of lives, map drawn, center returns to menu
// WON   | exit reached, map drawn, center returns to menu
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int MAP_WIDTH  = MAP_WIDTH_DEF,
    parameter int MAP_HEIGHT = MAP_HEIGHT_DEF,
    parameter int START_X    = 0,
    parameter int START_Y    = 11,
    parameter int EXIT_X     = 29,
    parameter int EXIT_Y     = 9,
    parameter int SHOW_EASY  = 150000000,
    parameter int SHOW_MED   = 100000000,
    parameter int SHOW_HARD  = 50000000,
    parameter int LIVES_EASY = 3,
    parameter int LIVES_MED  = 2,
    parameter int LIVES_HARD = 1
) (
    input  logic             clk,
    input  logic             reset,
    game_flow_ctrl_if.master bus
);

    localparam logic [MAP_WIDTH-1:0] COL_ONE = {{(MAP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0] START_XB = 8'(START_X);
    localparam logic [7:0] START_YB = 8'(START_Y);

    state_t               state_q, state_d;
    logic [3:0]           gs_q;
    logic [2:0]           sel_q, sel_d;
    logic [1:0]           sub_q, sub_d;
    logic [2:0]           diff_q, diff_d;
    logic [7:0]           px_q, px_d, py_q, py_d;
    logic [7:0]           tx_q, tx_d, ty_q, ty_d;
    logic [1:0]           lives_q, lives_d;
    logic                 vis_q, vis_d;
    logic                 busy_q, busy_d;
    logic [4:0]           addr_q, addr_d;
    logic                 mv_ok;
    logic [7:0]           mv_x, mv_y;
    logic                 wall_hit;
    logic                 timer_load;
    logic                 timer_dec;
    logic                 timer_zero;
    logic [TIMER_W-1:0]   timer_value;
    logic [TIMER_W-1:0]   timer_load_val;

    function automatic logic [TIMER_W-1:0] preview_len(input logic [2:0] d);
        case (d)
            DIFF_MED:  return TIMER_W'(SHOW_MED - 1);
            DIFF_HARD: return TIMER_W'(SHOW_HARD - 1);
            default:   return TIMER_W'(SHOW_EASY - 1);
        endcase
    endfunction

    function automatic logic [1:0] lives_for(input logic [2:0] d);
        case (d)
            DIFF_MED:  return 2'(LIVES_MED);
            DIFF_HARD: return 2'(LIVES_HARD);
            default:   return 2'(LIVES_EASY);
        endcase
    endfunction

    assign timer_load_val = preview_len(diff_q);
    assign timer_dec      = (state_q == ST_SHOW) && (timer_value != '0);
    assign wall_hit       = |(bus.rom_data & (COL_ONE << tx_q));

    show_timer #(.WIDTH(TIMER_W)) u_show_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_load_val),
        .dec        (timer_dec),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    // Pick the highest-priority direction pulse and check its target against the map edges.
    always_comb begin
        mv_ok = 1'b0;
        mv_x  = px_q;
        mv_y  = py_q;
        if (bus.btn_up) begin
            mv_ok = (py_q != 8'd0);
            mv_y  = py_q - 8'd1;
        end else if (bus.btn_down) begin
            mv_ok = (py_q != 8'(MAP_HEIGHT - 1));
            mv_y  = py_q + 8'd1;
        end else if (bus.btn_left) begin
            mv_ok = (px_q != 8'd0);
            mv_x  = px_q - 8'd1;
        end else if (bus.btn_right) begin
            mv_ok = (px_q != 8'(MAP_WIDTH - 1));
            mv_x  = px_q + 8'd1;
        end
    end

    // Next-state and next-output logic; every register holds unless a branch updates it.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        sub_d      = sub_q;
        diff_d     = diff_q;
        px_d       = px_q;
        py_d       = py_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        lives_d    = lives_q;
        vis_d      = vis_q;
        busy_d     = busy_q;
        addr_d     = addr_q;
        timer_load = 1'b0;

        case (state_q)
            ST_MENU: begin
                if (sub_q == SUB_MAIN) begin
                    if (bus.btn_up) begin
                        sel_d = {sel_q[0], sel_q[2:1]};
                    end else if (bus.btn_down) begin
                        sel_d = {sel_q[1:0], sel_q[2]};
                    end else if (bus.btn_center) begin
                        if (sel_q == SEL_START) begin
                            lives_d    = lives_for(diff_q);
                            px_d       = START_XB;
                            py_d       = START_YB;
                            timer_load = 1'b1;
                            vis_d      = 1'b1;
                            state_d    = ST_SHOW;
                        end else if (sel_q == SEL_DIFF) begin
                            sub_d = SUB_DIFF;
                        end else if (sel_q == SEL_INSTR) begin
                            sub_d = SUB_INSTR;
                        end
                    end
                end else if (sub_q == SUB_DIFF) begin
                    if (bus.btn_center) begin
                        sub_d = SUB_MAIN;
                    end else if (bus.btn_left) begin
                        diff_d = {diff_q[0], diff_q[2:1]};
                    end else if (bus.btn_right) begin
                        diff_d = {diff_q[1:0], diff_q[2]};
                    end
                end else if (bus.btn_center) begin
                    sub_d = SUB_MAIN;
                end
            end

            ST_SHOW: begin
                if (timer_zero) begin
                    vis_d   = 1'b0;
                    state_d = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (mv_ok) begin
                    tx_d    = mv_x;
                    ty_d    = mv_y;
                    addr_d  = mv_y[4:0];
                    busy_d  = 1'b1;
                    state_d = ST_RD;
                end
            end

            ST_RD: begin
                state_d = ST_EVAL;
            end

            ST_EVAL: begin
                busy_d = 1'b0;
                if (wall_hit) begin
                    lives_d = lives_q - 2'd1;
                    vis_d   = 1'b1;
                    if (lives_q == 2'd1) begin
                        state_d = ST_LOST;
                    end else begin
                        px_d       = START_XB;
                        py_d       = START_YB;
                        timer_load = 1'b1;
                        state_d    = ST_SHOW;
                    end
                end else begin
                    px_d = tx_q;
                    py_d = ty_q;
                    if (tx_q == 8'(EXIT_X) && ty_q == 8'(EXIT_Y)) begin
                        vis_d   = 1'b1;
                        state_d = ST_WON;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
            end

            ST_LOST, ST_WON: begin
                if (bus.btn_center) begin
                    sub_d   = SUB_MAIN;
                    px_d    = START_XB;
                    py_d    = START_YB;
                    vis_d   = 1'b0;
                    state_d = ST_MENU;
                end
            end

            default: begin
                state_d = ST_MENU;
            end
        endcase
    end

    // State and output registers; reset abandons any preview or move check in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_MENU;
            gs_q    <= GS_MENU;
            sel_q   <= SEL_START;
            sub_q   <= SUB_MAIN;
            diff_q  <= DIFF_EASY;
            px_q    <= START_XB;
            py_q    <= START_YB;
            tx_q    <= 8'd0;
            ty_q    <= 8'd0;
            lives_q <= 2'(LIVES_EASY);
            vis_q   <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            gs_q    <= state_to_gs(state_d);
            sel_q   <= sel_d;
            sub_q   <= sub_d;
            diff_q  <= diff_d;
            px_q    <= px_d;
            py_q    <= py_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            lives_q <= lives_d;
            vis_q   <= vis_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.rom_addr    = addr_q;
    assign bus.player_x    = px_q;
    assign bus.player_y    = py_q;
    assign bus.game_state  = gs_q;
    assign bus.menu_sel    = sel_q;
    assign bus.menu_sub    = sub_q;
    assign bus.difficulty  = diff_q;
    assign bus.map_visible = vis_q;
    assign bus.lives       = lives_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus random games against a
// cell-level game model with a 1-cycle-latency stub map ROM.
module tb_game_flow_ctrl;

    localparam int W = 30;
    localparam int H = 21;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    int show_len   [3] = '{8, 4, 2};
    int lives_init [3] = '{3, 2, 1};
    logic [W-1:0] rom_mem [H];

    // model: mode 0 menu, 1 in game, 2 lost, 3 won; sel/sub/diff as indices
    int m_mode, m_sel, m_sub, m_diff, m_x, m_y, m_lives, m_addr;

    game_flow_ctrl_if #(.MAP_WIDTH(W)) bus ();

    game_flow_ctrl #(
        .MAP_WIDTH(W), .MAP_HEIGHT(H), .START_X(0), .START_Y(11),
        .EXIT_X(29), .EXIT_Y(9),
        .SHOW_EASY(8), .SHOW_MED(4), .SHOW_HARD(2),
        .LIVES_EASY(3), .LIVES_MED(2), .LIVES_HARD(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        bus.rom_data <= (int'(bus.rom_addr) < H) ? rom_mem[bus.rom_addr] : '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [4:0] m);
        bus.btn_up     = m[0];
        bus.btn_down   = m[1];
        bus.btn_left   = m[2];
        bus.btn_right  = m[3];
        bus.btn_center = m[4];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_sel = 0; m_sub = 0; m_diff = 0;
        m_x = 0; m_y = 11; m_lives = 3; m_addr = 0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        model_reset();
        chk({tag, "_gs"},    bus.game_state, 1);
        chk({tag, "_sel"},   bus.menu_sel, 1);
        chk({tag, "_sub"},   bus.menu_sub, 0);
        chk({tag, "_diff"},  bus.difficulty, 1);
        chk({tag, "_x"},     bus.player_x, 0);
        chk({tag, "_y"},     bus.player_y, 11);
        chk({tag, "_lives"}, bus.lives, 3);
        chk({tag, "_vis"},   bus.map_visible, 0);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_addr"},  bus.rom_addr, 0);
    endtask

    // b: 0 up, 1 down, 2 left, 3 right, 4 center (never center on start here)
    task automatic menu_press(input int b);
        set_btns(5'(1 << b));
        tick();
        set_btns(5'b0);
        if (m_sub == 0) begin
            if (b == 0)      m_sel = (m_sel + 2) % 3;
            else if (b == 1) m_sel = (m_sel + 1) % 3;
            else if (b == 4) m_sub = m_sel;
        end else if (m_sub == 1) begin
            if (b == 4)      m_sub = 0;
            else if (b == 2) m_diff = (m_diff + 2) % 3;
            else if (b == 3) m_diff = (m_diff + 1) % 3;
        end else if (b == 4) begin
            m_sub = 0;
        end
        chk("menu_sel",  bus.menu_sel, 1 << m_sel);
        chk("menu_sub",  bus.menu_sub, m_sub);
        chk("menu_diff", bus.difficulty, 1 << m_diff);
        chk("menu_gs",   bus.game_state, 1);
    endtask

    task automatic count_preview(input int exp_len, input string tag);
        int cnt = 0;
        while (bus.map_visible === 1'b1 && cnt < 1000) begin
            cnt++;
            set_btns(5'($urandom_range(0, 31)));
            tick();
            set_btns(5'b0);
        end
        chk({tag, "_prev_len"}, cnt, exp_len);
        chk({tag, "_prev_gs"},  bus.game_state, 2);
        chk({tag, "_prev_x"},   bus.player_x, m_x);
    endtask

    task automatic start_game();
        set_btns(5'b10000);
        tick();
        set_btns(5'b0);
        m_mode = 1; m_x = 0; m_y = 11; m_lives = lives_init[m_diff];
        chk("start_gs",    bus.game_state, 2);
        chk("start_vis",   bus.map_visible, 1);
        chk("start_lives", bus.lives, m_lives);
        chk("start_x",     bus.player_x, 0);
        chk("start_y",     bus.player_y, 11);
        count_preview(show_len[m_diff], "start");
    endtask

    task automatic end_press();
        set_btns(5'b10000);
        tick();
        set_btns(5'b0);
        m_mode = 0; m_sub = 0; m_x = 0; m_y = 11;
        chk("end_gs",  bus.game_state, 1);
        chk("end_vis", bus.map_visible, 0);
        chk("end_x",   bus.player_x, 0);
        chk("end_y",   bus.player_y, 11);
        chk("end_sub", bus.menu_sub, 0);
    endtask

    // mask bits: 0 up, 1 down, 2 left, 3 right
    task automatic do_move(input logic [3:0] mask);
        int  dx = 0, dy = 0, tx, ty;
        bit  inb, wall;
        if (mask[0])      dy = -1;
        else if (mask[1]) dy = 1;
        else if (mask[2]) dx = -1;
        else if (mask[3]) dx = 1;
        tx  = m_x + dx;
        ty  = m_y + dy;
        inb = (dx != 0 || dy != 0) && tx >= 0 && tx < W && ty >= 0 && ty < H;
        set_btns({1'b0, mask});
        tick();
        set_btns(5'b0);
        if (!inb) begin
            chk("ign_busy", bus.busy, 0);
            chk("ign_addr", bus.rom_addr, m_addr);
            tick();
            chk("ign_x",  bus.player_x, m_x);
            chk("ign_y",  bus.player_y, m_y);
            chk("ign_gs", bus.game_state, 2);
            return;
        end
        m_addr = ty;
        chk("mv_addr",  bus.rom_addr, ty);
        chk("mv_busy1", bus.busy, 1);
        set_btns(5'($urandom_range(0, 31)));
        tick();
        set_btns(5'b0);
        chk("mv_busy2", bus.busy, 1);
        set_btns(5'($urandom_range(0, 31)));
        tick();
        set_btns(5'b0);
        wall = rom_mem[ty][tx];
        if (wall) begin
            m_lives--;
            if (m_lives == 0) m_mode = 2;
            else begin m_x = 0; m_y = 11; end
        end else begin
            m_x = tx;
            m_y = ty;
            if (tx == 29 && ty == 9) m_mode = 3;
        end
        chk("res_x",     bus.player_x, m_x);
        chk("res_y",     bus.player_y, m_y);
        chk("res_lives", bus.lives, m_lives);
        chk("res_gs",    bus.game_state, 1 << m_mode);
        chk("res_busy",  bus.busy, 0);
        chk("res_vis",   bus.map_visible, (wall || m_mode != 1) ? 1 : 0);
        if (wall && m_mode == 1) count_preview(show_len[m_diff], "wall");
    endtask

    task automatic clear_rom();
        for (int r = 0; r < H; r++) rom_mem[r] = '0;
    endtask

    initial begin
        reset = 1'b1;
        set_btns(5'b0);
        clear_rom();
        do_reset("rst");

        // menu navigation, then start on hard
        menu_press(0);
        menu_press(1);
        menu_press(1);
        menu_press(4);
        menu_press(3);
        menu_press(3);
        menu_press(4);
        menu_press(0);
        start_game();

        // legal move, boundary, simultaneous up+right, hard wall hit -> lost
        do_move(4'b1000);
        do_move(4'b0100);
        do_move(4'b0100);
        do_move(4'b1001);
        do_move(4'b0010);
        rom_mem[11][1] = 1'b1;
        do_move(4'b1000);
        end_press();

        // easy: three wall hits with re-previews
        menu_press(1);
        menu_press(4);
        menu_press(3);
        menu_press(4);
        menu_press(0);
        start_game();
        for (int i = 0; i < 3; i++) do_move(4'b1000);
        end_press();

        // walk to the exit
        clear_rom();
        start_game();
        for (int i = 0; i < 29; i++) do_move(4'b1000);
        do_move(4'b0001);
        do_move(4'b0001);
        end_press();

        // reset during the ROM read cycle
        start_game();
        set_btns(5'b01000);
        tick();
        set_btns(5'b0);
        chk("rc_busy", bus.busy, 1);
        do_reset("rc");
        repeat (3) tick();
        chk("rc_hold_x",    bus.player_x, 0);
        chk("rc_hold_busy", bus.busy, 0);

        // random games
        for (int g = 0; g < 8; g++) begin
            for (int r = 0; r < H; r++) rom_mem[r] = W'($urandom & $urandom & $urandom);
            rom_mem[11][0] = 1'b0;
            for (int k = 0; k < 8; k++) begin
                int b = $urandom_range(0, 4);
                if (!(b == 4 && m_sub == 0 && m_sel == 0)) menu_press(b);
            end
            if (m_sub != 0) menu_press(4);
            while (m_sel != 0) menu_press(0);
            start_game();
            for (int m = 0; m < 60 && m_mode == 1; m++) do_move(4'($urandom_range(0, 15)));
            if (m_mode == 2 || m_mode == 3) end_press();
            else do_reset("rnd_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
